// File: rtl/seq_mult_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier controller.
package seq_mult_pkg;

    localparam int MULT_WIDTH = 8;
    localparam int CNT_W      = $clog2(MULT_WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/eight_bit_adder.sv
// Combinational 8-bit ripple-carry adder shared with the multiply controller.
module eight_bit_adder (
    input  logic [7:0] num1,
    input  logic [7:0] num2,
    output logic [7:0] result,
    output logic       carry_out
);

    // Bit-serial carry chain, LSB first.
    always_comb begin
        logic carry_s;
        carry_s = 1'b0;
        result  = 8'd0;
        for (int i = 0; i < 8; i++) begin
            result[i] = num1[i] ^ num2[i] ^ carry_s;
            carry_s   = (num1[i] & num2[i]) | (carry_s & (num1[i] ^ num2[i]));
        end
        carry_out = carry_s;
    end

endmodule

// File: rtl/seq_mult_ctrl.sv
// Unsigned 8x8->16 shift-and-add multiply controller that time-shares an
// external 8-bit adder: one partial product per CALC cycle.
module seq_mult_ctrl
    import seq_mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     num1,
    input  logic [WIDTH-1:0]     num2,
    output logic [WIDTH-1:0]     add_a,
    output logic [WIDTH-1:0]     add_b,
    input  logic [WIDTH-1:0]     add_sum,
    input  logic                 add_cout,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     m_q, m_d;
    logic [WIDTH-1:0]     q_q, q_d;
    logic [WIDTH-1:0]     p_hi_q, p_hi_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   product_q, product_d;
    logic [WIDTH-1:0]     add_a_s, add_b_s;

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            m_q       <= '0;
            q_q       <= '0;
            p_hi_q    <= '0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            m_q       <= m_d;
            q_q       <= q_d;
            p_hi_q    <= p_hi_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    // Next-state, datapath update and adder operand selection.
    always_comb begin
        state_d   = state_q;
        m_d       = m_q;
        q_d       = q_q;
        p_hi_d    = p_hi_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        add_a_s   = {WIDTH{1'b0}};
        add_b_s   = {WIDTH{1'b0}};
        case (state_q)
            IDLE: begin
                if (start) begin
                    m_d     = num1;
                    q_d     = num2;
                    p_hi_d  = {WIDTH{1'b0}};
                    cnt_d   = {CNT_W{1'b0}};
                    state_d = CALC;
                end else begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                add_a_s = p_hi_q;
                add_b_s = q_q[0] ? m_q : {WIDTH{1'b0}};
                // Carry enters the top of P_hi; the sum LSB moves into Q as Q retires a bit.
                p_hi_d  = {add_cout, add_sum[WIDTH-1:1]};
                q_d     = {add_sum[0], q_q[WIDTH-1:1]};
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    product_d = {p_hi_d, q_d};
                    state_d   = DONE;
                end else begin
                    state_d   = CALC;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign add_a   = add_a_s;
    assign add_b   = add_b_s;
    assign busy    = (state_q != IDLE);
    assign done    = (state_q == DONE);
    assign product = product_q;

endmodule
